// File: rtl/life_env_loader_pkg.sv
// life_env_loader_pkg: grid geometry, environment type and FSM state encoding shared by the loader slice.
package life_env_loader_pkg;
  localparam int GRID_H = 16;
  localparam int GRID_W = 16;
  typedef logic [GRID_H-1:0][GRID_W-1:0] environment_t;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
endpackage

// File: rtl/life_env_loader_if.sv
// life_env_loader_if: seed stream, run control and environment/status bundle of the loader.
// Ports (slave side): in load_start, row_data, row_valid, run_en, next_env;
//                     out row_ready, cur_env, env_valid, gen_strobe, gen_count, state.
interface life_env_if import life_env_loader_pkg::*; #(parameter int GEN_CNT_W = 16) ();
  logic                 load_start;
  logic [GRID_W-1:0]    row_data;
  logic                 row_valid;
  logic                 row_ready;
  logic                 run_en;
  environment_t         next_env;
  environment_t         cur_env;
  logic                 env_valid;
  logic                 gen_strobe;
  logic [GEN_CNT_W-1:0] gen_count;
  state_t               state;
  modport master (output load_start, row_data, row_valid, run_en, next_env,
                  input  row_ready, cur_env, env_valid, gen_strobe, gen_count, state);
  modport slave  (input  load_start, row_data, row_valid, run_en, next_env,
                  output row_ready, cur_env, env_valid, gen_strobe, gen_count, state);
endinterface

// File: rtl/life_env_loader_gen_rate_divider.sv
// gen_rate_divider: counts 0..GEN_DIV-1 while enabled and pulses tc_o on the terminal count.
// Ports: clk, rst_n (async active-low), clear_i (forces count to 0, suppresses tc_o),
//        en_i (advance), tc_o (terminal-count pulse, combinational).
module gen_rate_divider #(
  parameter int GEN_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(GEN_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tc_o  = en_i && !clear_i && cnt_q == W'(GEN_DIV - 1);
    cnt_d = (clear_i || tc_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/life_env_loader.sv
// life_env_loader: owns the 16x16 Life environment; loads a seed row by row, then commits next_env at the generation rate.
// Ports: clk, rst_n (async active-low), bus (life_env_if.slave: seed stream, run_en, next_env in;
//        row_ready, cur_env, env_valid, gen_strobe, gen_count, state out).
module life_env_loader import life_env_loader_pkg::*; #(
  parameter int GEN_DIV   = 25_000_000,
  parameter int GEN_CNT_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  life_env_if.slave bus
);
  localparam int RW = $clog2(GRID_H);
  state_t               state_q, state_d;
  environment_t         cur_env_q, cur_env_d;
  logic [RW-1:0]        row_idx_q, row_idx_d;
  logic [GEN_CNT_W-1:0] gen_count_q, gen_count_d;
  logic                 env_valid_q, env_valid_d, strobe_q, strobe_d;
  logic                 row_ready, hs, last_row, div_en, tc;
  // load_start masks row_ready so a restart never also writes a row
  assign row_ready = state_q == LOAD && !bus.load_start;
  assign hs        = bus.row_valid && row_ready;
  assign last_row  = hs && row_idx_q == RW'(GRID_H - 1);
  assign div_en    = state_q == RUN && bus.run_en;
  // held clear outside RUN so every RUN entry starts a full period; load_start kills a coincident tc
  gen_rate_divider #(.GEN_DIV(GEN_DIV)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.load_start || !div_en),
    .en_i    (div_en),
    .tc_o    (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = bus.load_start  ? LOAD :
              state_q == IDLE ? IDLE :
              state_q == LOAD ? (last_row ? HOLD : LOAD) :
              bus.run_en      ? RUN : HOLD;
  always_comb begin
    cur_env_d = cur_env_q;
    if (bus.load_start) cur_env_d = '0;
    else if (hs)        cur_env_d[row_idx_q] = bus.row_data;
    else if (tc)        cur_env_d = bus.next_env;
    row_idx_d   = bus.load_start ? '0 : hs ? row_idx_q + 1'b1 : row_idx_q;
    gen_count_d = bus.load_start ? '0 : tc ? gen_count_q + 1'b1 : gen_count_q;
    env_valid_d = bus.load_start ? 1'b0 : last_row ? 1'b1 : env_valid_q;
    strobe_d    = tc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_env_q   <= '0;
      row_idx_q   <= '0;
      gen_count_q <= '0;
      env_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      cur_env_q   <= cur_env_d;
      row_idx_q   <= row_idx_d;
      gen_count_q <= gen_count_d;
      env_valid_q <= env_valid_d;
      strobe_q    <= strobe_d;
    end
  always_comb begin
    bus.row_ready  = row_ready;
    bus.cur_env    = cur_env_q;
    bus.env_valid  = env_valid_q;
    bus.gen_strobe = strobe_q;
    bus.gen_count  = gen_count_q;
    bus.state      = state_q;
  end
endmodule

// File: tb/tb_life_env_loader.sv
// tb_life_env_loader: drives two loaders (GEN_DIV=4/16-bit count and GEN_DIV=2/4-bit count) from shared stimulus, checks against a Life model.
module tb_life_env_loader;
  import life_env_loader_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load_start = 1'b0, row_valid = 1'b0, run_en = 1'b0;
  logic [GRID_W-1:0] row_data = '0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  function automatic environment_t life_next(environment_t e);
    environment_t n;
    int c;
    for (int r = 0; r < GRID_H; r++)
      for (int j = 0; j < GRID_W; j++) begin
        c = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) c += int'(e[(r + dr + GRID_H) % GRID_H][(j + dc + GRID_W) % GRID_W]);
        n[r][j] = (c == 3) || (c == 2 && e[r][j]);
      end
    return n;
  endfunction

  life_env_if #(.GEN_CNT_W(16)) ifa ();
  life_env_if #(.GEN_CNT_W(4))  ifb ();
  assign ifa.load_start = load_start;
  assign ifa.row_data   = row_data;
  assign ifa.row_valid  = row_valid;
  assign ifa.run_en     = run_en;
  assign ifa.next_env   = life_next(ifa.cur_env);
  assign ifb.load_start = load_start;
  assign ifb.row_data   = row_data;
  assign ifb.row_valid  = row_valid;
  assign ifb.run_en     = run_en;
  assign ifb.next_env   = life_next(ifb.cur_env);

  life_env_loader #(.GEN_DIV(4), .GEN_CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  life_env_loader #(.GEN_DIV(2), .GEN_CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_env(input environment_t seed);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int r = 0; r < GRID_H; r++) begin
      row_valid = 1'b1;
      row_data  = seed[r];
      step();
    end
    row_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      load_start = 1'($urandom);
      row_valid  = 1'($urandom);
      run_en     = 1'($urandom);
      row_data   = 16'($urandom);
      @(negedge clk);
      vectors++; if (ifa.cur_env !== '0) begin miscompares++; $display("FAIL reset_env_a got %h exp 0", ifa.cur_env); end
      vectors++; if (ifa.env_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid_a got %b exp 0", ifa.env_valid); end
      vectors++; if (ifa.row_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_a got %b exp 0", ifa.row_ready); end
      vectors++; if (ifa.gen_count !== 16'd0) begin miscompares++; $display("FAIL reset_count_a got %0d exp 0", ifa.gen_count); end
      vectors++; if (ifa.state !== IDLE) begin miscompares++; $display("FAIL reset_state_a got %0d exp 0", ifa.state); end
      vectors++; if (ifa.gen_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe_a got %b exp 0", ifa.gen_strobe); end
      vectors++; if (ifb.state !== IDLE || ifb.cur_env !== '0) begin miscompares++; $display("FAIL reset_b state %0d env %h exp 0/0", ifb.state, ifb.cur_env); end
    end
    load_start = 1'b0; row_valid = 1'b0; run_en = 1'b1;
    rst_n = 1'b1;
    step(); step();
    vectors++; if (ifa.state !== IDLE) begin miscompares++; $display("FAIL idle_ignores_run got %0d exp 0", ifa.state); end
    run_en = 1'b0;
  endtask

  task automatic test_glider();
    environment_t seed = '0;
    seed[0] = 16'h0002; seed[1] = 16'h0004; seed[2] = 16'h0007;
    load_start = 1'b1;
    #1;
    vectors++; if (ifa.row_ready !== 1'b0) begin miscompares++; $display("FAIL ready_in_start_cycle got %b exp 0", ifa.row_ready); end
    @(negedge clk);
    step();
    load_start = 1'b0;
    for (int r = 0; r < GRID_H; r++) begin
      row_valid = 1'b1;
      row_data  = seed[r];
      if (r == 15) begin
        vectors++; if (ifa.env_valid !== 1'b0) begin miscompares++; $display("FAIL valid_early got %b exp 0", ifa.env_valid); end
      end
      step();
      if (r == 3 || r == 9) begin
        row_valid = 1'b0;
        row_data  = 16'($urandom);
        for (int g = 0; g < 2; g++) begin
          step();
          vectors++; if (ifa.state !== LOAD || ifa.env_valid !== 1'b0) begin miscompares++; $display("FAIL gap_stall r=%0d state %0d valid %b exp 1/0", r, ifa.state, ifa.env_valid); end
        end
      end
    end
    row_valid = 1'b0;
    vectors++; if (ifa.env_valid !== 1'b1) begin miscompares++; $display("FAIL glider_valid got %b exp 1", ifa.env_valid); end
    vectors++; if (ifa.state !== HOLD) begin miscompares++; $display("FAIL glider_state got %0d exp 2", ifa.state); end
    vectors++; if (ifa.cur_env !== seed) begin miscompares++; $display("FAIL glider_env_a got %h exp %h", ifa.cur_env, seed); end
    vectors++; if (ifb.cur_env !== seed) begin miscompares++; $display("FAIL glider_env_b got %h exp %h", ifb.cur_env, seed); end
    vectors++; if (ifa.row_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready got %b exp 0", ifa.row_ready); end
    step();
    vectors++; if (ifa.state !== HOLD || ifa.row_ready !== 1'b0) begin miscompares++; $display("FAIL hold_stays state %0d ready %b exp 2/0", ifa.state, ifa.row_ready); end
  endtask

  task automatic test_run_blinker();
    environment_t seed = '0, vert = '0, ea, eb;
    seed[5] = 16'h0070;
    vert[4] = 16'h0020; vert[5] = 16'h0020; vert[6] = 16'h0020;
    load_env(seed);
    ea = seed; eb = seed;
    run_en = 1'b1;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k % 4 == 0) ea = life_next(ea);
      if (k % 2 == 0) eb = life_next(eb);
      vectors++; if (ifa.gen_strobe !== 1'(k % 4 == 0)) begin miscompares++; $display("FAIL run_strobe_a k=%0d got %b", k, ifa.gen_strobe); end
      vectors++; if (ifa.gen_count !== 16'(k / 4)) begin miscompares++; $display("FAIL run_count_a k=%0d got %0d exp %0d", k, ifa.gen_count, k / 4); end
      vectors++; if (ifa.cur_env !== ea) begin miscompares++; $display("FAIL run_env_a k=%0d got %h exp %h", k, ifa.cur_env, ea); end
      vectors++; if (ifb.gen_strobe !== 1'(k % 2 == 0) || ifb.gen_count !== 4'(k / 2)) begin miscompares++; $display("FAIL run_b k=%0d strobe %b count %0d exp count %0d", k, ifb.gen_strobe, ifb.gen_count, k / 2); end
      vectors++; if (ifb.cur_env !== eb) begin miscompares++; $display("FAIL run_env_b k=%0d got %h exp %h", k, ifb.cur_env, eb); end
      if (k == 4 || k == 12) begin
        vectors++; if (ifa.cur_env !== vert) begin miscompares++; $display("FAIL blinker_vertical k=%0d got %h exp %h", k, ifa.cur_env, vert); end
      end
      if (k == 8) begin
        vectors++; if (ifa.cur_env !== seed) begin miscompares++; $display("FAIL blinker_horizontal got %h exp %h", ifa.cur_env, seed); end
      end
    end
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (ifa.state !== HOLD || ifa.gen_strobe !== 1'b0 || ifa.gen_count !== 16'd3) begin miscompares++; $display("FAIL pause_a state %0d strobe %b count %0d exp 2/0/3", ifa.state, ifa.gen_strobe, ifa.gen_count); end
      vectors++; if (ifb.gen_strobe !== 1'b0 || ifb.gen_count !== 4'd7) begin miscompares++; $display("FAIL pause_b strobe %b count %0d exp 0/7", ifb.gen_strobe, ifb.gen_count); end
    end
    run_en = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++; if (ifa.gen_strobe !== 1'(k == 4) || ifa.gen_count !== (k == 4 ? 16'd4 : 16'd3)) begin miscompares++; $display("FAIL resume_a k=%0d strobe %b count %0d", k, ifa.gen_strobe, ifa.gen_count); end
    end
    run_en = 1'b0;
    step();
  endtask

  task automatic test_load_abort();
    environment_t exp_env = '0;
    logic [GRID_W-1:0] first;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      row_valid = 1'b1;
      row_data  = 16'($urandom);
      step();
    end
    load_start = 1'b1;
    row_data   = 16'hbeef;
    #1;
    vectors++; if (ifa.row_ready !== 1'b0) begin miscompares++; $display("FAIL restart_ready got %b exp 0", ifa.row_ready); end
    @(negedge clk);
    step();
    load_start = 1'b0;
    vectors++; if (ifa.state !== LOAD) begin miscompares++; $display("FAIL abort_state got %0d exp 1", ifa.state); end
    vectors++; if (ifa.cur_env !== '0 || ifa.env_valid !== 1'b0) begin miscompares++; $display("FAIL abort_clear env %h valid %b exp 0/0", ifa.cur_env, ifa.env_valid); end
    first = 16'($urandom) | 16'h1;
    row_data = first;
    step();
    exp_env[0] = first;
    vectors++; if (ifa.cur_env !== exp_env) begin miscompares++; $display("FAIL abort_row0 got %h exp %h", ifa.cur_env, exp_env); end
    for (int r = 1; r < GRID_H; r++) begin
      exp_env[r] = 16'($urandom);
      row_data   = exp_env[r];
      step();
    end
    row_valid = 1'b0;
    vectors++; if (ifa.state !== HOLD || ifa.cur_env !== exp_env) begin miscompares++; $display("FAIL abort_reload state %0d env %h exp %h", ifa.state, ifa.cur_env, exp_env); end
  endtask

  task automatic test_wrap();
    environment_t seed, eb;
    for (int r = 0; r < GRID_H; r++) seed[r] = 16'($urandom);
    load_env(seed);
    eb = seed;
    run_en = 1'b1;
    step();
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k % 2 == 0) eb = life_next(eb);
      vectors++; if (ifb.gen_count !== 4'(k / 2) || ifb.gen_strobe !== 1'(k % 2 == 0)) begin miscompares++; $display("FAIL wrap_b k=%0d count %0d strobe %b exp %0d", k, ifb.gen_count, ifb.gen_strobe, 4'(k / 2)); end
      vectors++; if (ifb.cur_env !== eb) begin miscompares++; $display("FAIL wrap_env_b k=%0d got %h exp %h", k, ifb.cur_env, eb); end
    end
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    run_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (ifb.state !== LOAD || ifb.gen_strobe !== 1'b0 || ifb.gen_count !== 4'd0 || ifb.cur_env !== '0) begin miscompares++; $display("FAIL tc_vs_load_b i=%0d state %0d strobe %b count %0d", i, ifb.state, ifb.gen_strobe, ifb.gen_count); end
      vectors++; if (ifa.gen_strobe !== 1'b0 || ifa.gen_count !== 16'd0 || ifa.cur_env !== '0) begin miscompares++; $display("FAIL tc_vs_load_a i=%0d strobe %b count %0d", i, ifa.gen_strobe, ifa.gen_count); end
      step();
    end
  endtask

  task automatic test_async_reset();
    environment_t seed = '0;
    seed[5] = 16'h0070;
    load_env(seed);
    run_en = 1'b1;
    step();
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (ifa.cur_env !== '0 || ifa.env_valid !== 1'b0 || ifa.gen_count !== 16'd0) begin miscompares++; $display("FAIL async_a env %h valid %b count %0d exp 0", ifa.cur_env, ifa.env_valid, ifa.gen_count); end
    vectors++; if (ifa.state !== IDLE || ifa.row_ready !== 1'b0 || ifa.gen_strobe !== 1'b0) begin miscompares++; $display("FAIL async_a_ctl state %0d ready %b strobe %b exp 0", ifa.state, ifa.row_ready, ifa.gen_strobe); end
    vectors++; if (ifb.state !== IDLE || ifb.gen_count !== 4'd0 || ifb.cur_env !== '0) begin miscompares++; $display("FAIL async_b state %0d count %0d exp 0", ifb.state, ifb.gen_count); end
    @(negedge clk);
    run_en = 1'b0;
    rst_n  = 1'b1;
    step();
    vectors++; if (ifa.state !== IDLE || ifa.env_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset state %0d valid %b exp 0/0", ifa.state, ifa.env_valid); end
  endtask

  initial begin
    test_reset();
    test_glider();
    test_run_blinker();
    test_load_abort();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
